// File: rtl/esn_readout.sv
// Linear readout for an echo-state network: y = sum W[i]*x[i], one MAC per clock,
// with a writable signed weight file and a saturated result plus one-cycle valid pulse.
module esn_readout #(
  parameter int RESERVOIR_SIZE = 3,
  parameter int DATA_WIDTH     = 3,
  parameter int WEIGHT_WIDTH   = 4,
  parameter int ADDR_WIDTH     = 2,
  parameter int ACC_WIDTH      = 12
) (
  input  logic                                 iClk,
  input  logic                                 iRst_n,
  input  logic                                 iEn,
  input  logic [DATA_WIDTH*RESERVOIR_SIZE-1:0] iState,
  input  logic                                 iStart,
  input  logic                                 iWeWeight,
  input  logic [ADDR_WIDTH-1:0]                iWeightAddr,
  input  logic [WEIGHT_WIDTH-1:0]              iWeightData,
  output logic [ACC_WIDTH-1:0]                 oY,
  output logic                                 oValid,
  output logic                                 oBusy
);

  // Accumulator is wide enough that the sum never wraps and the clamp bounds fit inside it.
  localparam int MIN_W = DATA_WIDTH + WEIGHT_WIDTH + ADDR_WIDTH + 1;
  localparam int INT_W = (MIN_W > ACC_WIDTH) ? MIN_W : ACC_WIDTH + 1;
  localparam int NUM_W = 2 ** ADDR_WIDTH;

  localparam logic signed [INT_W-1:0] SAT_MAX =
    {{(INT_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [INT_W-1:0] SAT_MIN =
    {{(INT_W-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                           state_q;
  logic [DATA_WIDTH*RESERVOIR_SIZE-1:0] snap_q;
  logic signed [INT_W-1:0]          acc_q;
  logic signed [INT_W-1:0]          acc_d;
  logic [ADDR_WIDTH-1:0]            idx_q;
  logic [WEIGHT_WIDTH-1:0]          weight_q [NUM_W];
  logic [ACC_WIDTH-1:0]             y_q;
  logic                             valid_q;

  logic [WEIGHT_WIDTH-1:0]          wSel;
  logic [DATA_WIDTH-1:0]            xSel;
  logic signed [INT_W-1:0]          wExt;
  logic signed [INT_W-1:0]          xExt;
  logic signed [INT_W-1:0]          prod;
  logic [ACC_WIDTH-1:0]             satY;

  always_comb begin
    wSel = weight_q[idx_q];
    xSel = '0;
    for (int i = 0; i < RESERVOIR_SIZE; i++) begin
      if (idx_q == ADDR_WIDTH'(i)) xSel = snap_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
    wExt  = {{(INT_W-WEIGHT_WIDTH){wSel[WEIGHT_WIDTH-1]}}, wSel};
    xExt  = {{(INT_W-DATA_WIDTH){1'b0}}, xSel};
    prod  = wExt * xExt;
    acc_d = acc_q + prod;
    if (acc_q > SAT_MAX)      satY = SAT_MAX[ACC_WIDTH-1:0];
    else if (acc_q < SAT_MIN) satY = SAT_MIN[ACC_WIDTH-1:0];
    else                      satY = acc_q[ACC_WIDTH-1:0];
  end

  // Weight writes are only accepted while idle, so a readout never sees a mixed weight set.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      snap_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < NUM_W; i++) weight_q[i] <= '0;
    end else if (iEn) begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (iStart) begin
            snap_q  <= iState;
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= ACC;
          end
        end
        ACC: begin
          acc_q <= acc_d;
          idx_q <= idx_q + ADDR_WIDTH'(1);
          if (idx_q == ADDR_WIDTH'(RESERVOIR_SIZE-1)) state_q <= DONE;
        end
        DONE: begin
          y_q     <= satY;
          valid_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (state_q == IDLE && iWeWeight && int'(iWeightAddr) < RESERVOIR_SIZE)
        weight_q[iWeightAddr] <= iWeightData;
    end
  end

  assign oY     = y_q;
  assign oValid = valid_q;
  assign oBusy  = (state_q != IDLE);

endmodule

// File: tb/tb_esn_readout.sv
// Directed bench for esn_readout: hand-computed readouts, stalls, busy rules,
// weight-write corner cases, saturation on a narrow instance, and mid-readout reset.
module tb_esn_readout;

  logic        clk;
  logic        rstN;
  logic        en;
  logic [8:0]  stateVec;
  logic        start;
  logic        we;
  logic [1:0]  wAddr;
  logic [3:0]  wData;
  logic [11:0] y;
  logic        valid;
  logic        busy;
  logic [5:0]  yS;
  logic        validS;
  logic        busyS;

  int checks   = 0;
  int failures = 0;
  int lat;
  int busyCnt;

  esn_readout #(.ACC_WIDTH(12)) dut (
    .iClk(clk), .iRst_n(rstN), .iEn(en), .iState(stateVec), .iStart(start),
    .iWeWeight(we), .iWeightAddr(wAddr), .iWeightData(wData),
    .oY(y), .oValid(valid), .oBusy(busy)
  );

  esn_readout #(.ACC_WIDTH(6)) dutSat (
    .iClk(clk), .iRst_n(rstN), .iEn(en), .iState(stateVec), .iStart(start),
    .iWeWeight(we), .iWeightAddr(wAddr), .iWeightData(wData),
    .oY(yS), .oValid(validS), .oBusy(busyS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic writeWeight(input logic [1:0] a, input logic [3:0] d);
    we = 1'b1; wAddr = a; wData = d;
    tick();
    we = 1'b0;
  endtask

  task automatic applyStimulus(input logic [8:0] x);
    stateVec = x; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts enabled-or-not cycles after the start edge until oValid, bounded.
  task automatic waitValid(output int l, output int b);
    l = 0;
    b = busy ? 1 : 0;
    while (!valid && l < 50) begin
      tick();
      l++;
      if (busy) b++;
    end
  endtask

  initial begin
    rstN = 1'b0; en = 1'b1; stateVec = '0; start = 1'b0;
    we = 1'b0; wAddr = '0; wData = '0;
    tick(); tick();
    checkOutput("reset_y", 32'($signed(y)), 0);
    checkOutput("reset_valid", 32'(valid), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    rstN = 1'b1;
    tick();

    // Basic readout: W={1,-2,3}, x={5,3,7} -> 20
    writeWeight(2'd0, 4'd1);
    writeWeight(2'd1, 4'hE);
    writeWeight(2'd2, 4'd3);
    applyStimulus({3'd7, 3'd3, 3'd5});
    checkOutput("basic_busy_after_start", 32'(busy), 1);
    waitValid(lat, busyCnt);
    checkOutput("basic_latency", lat, 4);
    checkOutput("basic_busy_cycles", busyCnt, 4);
    checkOutput("basic_y", 32'($signed(y)), 20);
    tick();
    checkOutput("basic_valid_single", 32'(valid), 0);
    checkOutput("basic_y_hold", 32'($signed(y)), 20);

    // Write to address 3 is dropped; x={1,2,3} -> 1-4+9 = 6
    writeWeight(2'd3, 4'd7);
    applyStimulus({3'd3, 3'd2, 3'd1});
    waitValid(lat, busyCnt);
    checkOutput("addr3_latency", lat, 4);
    checkOutput("addr3_y", 32'($signed(y)), 6);

    // Stall: iEn low for 3 cycles after the first MAC -> valid 7 cycles after start
    applyStimulus({3'd7, 3'd3, 3'd5});
    lat = 0;
    while (!valid && lat < 50) begin
      if (lat == 1) en = 1'b0;
      if (lat == 4) begin
        checkOutput("stall_busy", 32'(busy), 1);
        checkOutput("stall_valid", 32'(valid), 0);
        checkOutput("stall_y_held", 32'($signed(y)), 6);
        en = 1'b1;
      end
      tick();
      lat++;
    end
    en = 1'b1;
    checkOutput("stall_latency", lat, 7);
    checkOutput("stall_y", 32'($signed(y)), 20);
    tick();

    // Busy rules: start, weight write and iState change mid-readout are all ignored
    applyStimulus({3'd7, 3'd3, 3'd5});
    tick();
    stateVec = 9'h1FF; start = 1'b1; we = 1'b1; wAddr = 2'd0; wData = 4'hF;
    tick();
    start = 1'b0; we = 1'b0; stateVec = '0;
    checkOutput("busy_ignore_busy", 32'(busy), 1);
    waitValid(lat, busyCnt);
    checkOutput("busy_ignore_latency", lat, 2);
    checkOutput("busy_ignore_y", 32'($signed(y)), 20);
    // Back-to-back start on the valid cycle; W0 must still be 1 -> 6
    applyStimulus({3'd3, 3'd2, 3'd1});
    waitValid(lat, busyCnt);
    checkOutput("b2b_latency", lat + 1, 5);
    checkOutput("b2b_y", 32'($signed(y)), 6);
    tick();

    // Write W0=-1 on the same edge as start: -5-6+21 = 10
    stateVec = {3'd7, 3'd3, 3'd5}; start = 1'b1;
    we = 1'b1; wAddr = 2'd0; wData = 4'hF;
    tick();
    start = 1'b0; we = 1'b0;
    waitValid(lat, busyCnt);
    checkOutput("wr_start_latency", lat, 4);
    checkOutput("wr_start_y", 32'($signed(y)), 10);

    // Saturation: W all 7, x all 7 -> 147 (12b) / 31 (6b)
    writeWeight(2'd0, 4'd7);
    writeWeight(2'd1, 4'd7);
    writeWeight(2'd2, 4'd7);
    applyStimulus(9'h1FF);
    waitValid(lat, busyCnt);
    checkOutput("sat_pos_wide", 32'($signed(y)), 147);
    checkOutput("sat_pos_narrow", 32'($signed(yS)), 31);
    checkOutput("sat_pos_narrow_valid", 32'(validS), 1);
    // W all -8, x all 7 -> -168 (12b) / -32 (6b)
    writeWeight(2'd0, 4'h8);
    writeWeight(2'd1, 4'h8);
    writeWeight(2'd2, 4'h8);
    applyStimulus(9'h1FF);
    waitValid(lat, busyCnt);
    checkOutput("sat_neg_wide", 32'($signed(y)), -168);
    checkOutput("sat_neg_narrow", 32'($signed(yS)), -32);

    // Reset during ACC clears outputs immediately and zeroes the weights
    applyStimulus({3'd7, 3'd3, 3'd5});
    tick();
    rstN = 1'b0;
    #1;
    checkOutput("rst_mid_y", 32'($signed(y)), 0);
    checkOutput("rst_mid_valid", 32'(valid), 0);
    checkOutput("rst_mid_busy", 32'(busy), 0);
    rstN = 1'b1;
    tick();
    checkOutput("rst_no_valid", 32'(valid), 0);
    applyStimulus({3'd7, 3'd3, 3'd5});
    waitValid(lat, busyCnt);
    checkOutput("rst_after_latency", lat, 4);
    checkOutput("rst_after_y", 32'($signed(y)), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
